// File: rtl/alu_sequencer_if.sv
// Request / ALU / response bundle between the ALU sequencer and its environment.
// The slave side is the sequencer; the master side supplies requests, the ALU results and the consumer.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_floating;
  logic        req_form;
  logic [1:0]  req_precision;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_c;
  logic [31:0] req_d;
  logic [3:0]  req_tag;

  logic [2:0]  alu_op;
  logic        alu_floating;
  logic        alu_form;
  logic [1:0]  alu_precision;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic [31:0] alu_d;
  logic [31:0] alu_y1;
  logic [31:0] alu_y2;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;

  modport master (
    output req_valid, req_op, req_floating, req_form, req_precision,
           req_a, req_b, req_c, req_d, req_tag,
    input  req_ready,
    input  alu_op, alu_floating, alu_form, alu_precision,
           alu_a, alu_b, alu_c, alu_d,
    output alu_y1, alu_y2,
    input  rsp_valid, rsp_result, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_floating, req_form, req_precision,
           req_a, req_b, req_c, req_d, req_tag,
    output req_ready,
    output alu_op, alu_floating, alu_form, alu_precision,
           alu_a, alu_b, alu_c, alu_d,
    input  alu_y1, alu_y2,
    output rsp_valid, rsp_result, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issues one request at a time to an external combinational ALU, waits SETTLE_CYCLES,
// then captures {Y1,Y2} with its tag into a 2-entry in-order result FIFO.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sequencer_if.slave     bus,
  output logic               busy,
  output logic [15:0]        ops_done
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  settle_cnt;
  logic [3:0]  tag;
  logic        accept;
  logic        capture;
  logic        pop;

  // Each entry holds {tag, y1, y2}; rd_ptr selects the head shown on the response port.
  logic [67:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  assign bus.req_ready = (state == IDLE) && (fifo_count < 2'd2);
  assign bus.rsp_valid = (fifo_count != 2'd0);
  assign {bus.rsp_tag, bus.rsp_result} = fifo_mem[rd_ptr];
  assign pop  = bus.rsp_valid && bus.rsp_ready;
  assign busy = (state == ISSUE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (settle_cnt == 4'd1) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ALU drive holds the last accepted request until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_op        <= '0;
      bus.alu_floating  <= 1'b0;
      bus.alu_form      <= 1'b0;
      bus.alu_precision <= '0;
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.alu_c         <= '0;
      bus.alu_d         <= '0;
      tag               <= '0;
      settle_cnt        <= '0;
    end else if (accept) begin
      bus.alu_op        <= bus.req_op;
      bus.alu_floating  <= bus.req_floating;
      bus.alu_form      <= bus.req_form;
      bus.alu_precision <= bus.req_precision;
      bus.alu_a         <= bus.req_a;
      bus.alu_b         <= bus.req_b;
      bus.alu_c         <= bus.req_c;
      bus.alu_d         <= bus.req_d;
      tag               <= bus.req_tag;
      settle_cnt        <= 4'(SETTLE_CYCLES);
    end else if (state == ISSUE) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_done <= '0;
    else if (capture) ops_done <= ops_done + 16'd1;
  end

  // Push cannot happen while full because req_ready blocks accepts at count 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
    end else begin
      if (capture) begin
        fifo_mem[wr_ptr] <= {tag, bus.alu_y1, bus.alu_y2};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, capture} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against a transaction-level queue model.
// A second instance with SETTLE_CYCLES=4 covers the long-latency and mid-flight reset cases.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy1, busy4;
  logic [15:0] ops1, ops4;

  always #5 clk = ~clk;

  alu_sequencer_if bus1 ();
  alu_sequencer_if bus4 ();

  alu_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1), .ops_done(ops1));
  alu_sequencer #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave), .busy(busy4), .ops_done(ops4));

  // External ALU: add/subtract of A,B,C as 64-bit signed; other opcodes mix every field.
  function automatic logic [63:0] aluRef(input logic [2:0] op, input logic fl, input logic fm,
                                         input logic [1:0] pr, input logic [31:0] a, b, c, d);
    logic signed [63:0] sa, sb, sc;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sc = {{32{c[31]}}, c};
    if (op == 3'd0) return sa + sb + sc;
    if (op == 3'd4) return sa - sb - sc;
    return {a ^ d ^ {29'd0, op}, b ^ c ^ {28'd0, fl, fm, pr}};
  endfunction

  assign {bus1.alu_y1, bus1.alu_y2} = aluRef(bus1.alu_op, bus1.alu_floating, bus1.alu_form,
                                             bus1.alu_precision, bus1.alu_a, bus1.alu_b, bus1.alu_c, bus1.alu_d);
  assign {bus4.alu_y1, bus4.alu_y2} = aluRef(bus4.alu_op, bus4.alu_floating, bus4.alu_form,
                                             bus4.alu_precision, bus4.alu_a, bus4.alu_b, bus4.alu_c, bus4.alu_d);

  int vectors = 0;
  int miscompares = 0;

  bit           mInflight;
  logic [67:0]  mPend;
  logic [67:0]  mQ[$];
  logic [15:0]  mOps;
  logic [134:0] mDrive;
  logic [3:0]   poppedTags[$];

  task automatic checkOutput(input string tag, input logic [134:0] actual, input logic [134:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    mInflight = 1'b0;
    mPend     = '0;
    mQ.delete();
    mOps      = '0;
    mDrive    = '0;
  endtask

  task automatic checkAll();
    checkOutput("rsp_valid", 135'(bus1.rsp_valid), 135'(mQ.size() != 0));
    if (mQ.size() != 0) checkOutput("rsp_head", 135'({bus1.rsp_tag, bus1.rsp_result}), 135'(mQ[0]));
    checkOutput("req_ready", 135'(bus1.req_ready), 135'(!mInflight && mQ.size() < 2));
    checkOutput("busy", 135'(busy1), 135'(mInflight));
    checkOutput("ops_done", 135'(ops1), 135'(mOps));
    checkOutput("alu_drive", {bus1.alu_op, bus1.alu_floating, bus1.alu_form, bus1.alu_precision,
                              bus1.alu_a, bus1.alu_b, bus1.alu_c, bus1.alu_d}, mDrive);
  endtask

  task automatic checkReset();
    checkOutput("rst_rsp_valid", 135'({bus1.rsp_valid, bus4.rsp_valid}), 135'(0));
    checkOutput("rst_rsp_head", 135'({bus1.rsp_tag, bus1.rsp_result, bus4.rsp_tag, bus4.rsp_result}), 135'(0));
    checkOutput("rst_busy", 135'({busy1, busy4}), 135'(0));
    checkOutput("rst_ops_done", 135'({ops1, ops4}), 135'(0));
    checkOutput("rst_alu1", {bus1.alu_op, bus1.alu_floating, bus1.alu_form, bus1.alu_precision,
                             bus1.alu_a, bus1.alu_b, bus1.alu_c, bus1.alu_d}, 135'(0));
    checkOutput("rst_alu4", {bus4.alu_op, bus4.alu_floating, bus4.alu_form, bus4.alu_precision,
                             bus4.alu_a, bus4.alu_b, bus4.alu_c, bus4.alu_d}, 135'(0));
    checkOutput("rst_req_ready", 135'({bus1.req_ready, bus4.req_ready}), 135'(2'b11));
  endtask

  // One clock of stimulus on dut1; the model advances by what happened at that edge.
  task automatic applyStimulus(input bit valid, input logic [2:0] op, input logic fl, input logic fm,
                               input logic [1:0] pr, input logic [31:0] a, b, c, d,
                               input logic [3:0] tag, input bit rdy, output bit fired);
    bit mReady, popNow;
    bus1.req_valid     = valid;
    bus1.req_op        = op;
    bus1.req_floating  = fl;
    bus1.req_form      = fm;
    bus1.req_precision = pr;
    bus1.req_a         = a;
    bus1.req_b         = b;
    bus1.req_c         = c;
    bus1.req_d         = d;
    bus1.req_tag       = tag;
    bus1.rsp_ready     = rdy;
    mReady = !mInflight && (mQ.size() < 2);
    fired  = valid && mReady && rst_n;
    popNow = (mQ.size() != 0) && rdy && rst_n;
    if (popNow) poppedTags.push_back(bus1.rsp_tag);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (popNow) void'(mQ.pop_front());
      if (mInflight) begin
        mQ.push_back(mPend);
        mOps++;
        mInflight = 1'b0;
      end
      if (fired) begin
        mInflight = 1'b1;
        mPend     = {tag, aluRef(op, fl, fm, pr, a, b, c, d)};
        mDrive    = {op, fl, fm, pr, a, b, c, d};
      end
    end
    checkAll();
  endtask

  task automatic idle(input bit rdy);
    bit f;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, rdy, f);
  endtask

  task automatic sendOp(input logic [2:0] op, input logic fl, input logic fm, input logic [1:0] pr,
                        input logic [31:0] a, b, c, d, input logic [3:0] tag, input bit rdy);
    bit f;
    f = 1'b0;
    for (int k = 0; k < 20 && !f; k++) applyStimulus(1'b1, op, fl, fm, pr, a, b, c, d, tag, rdy, f);
    if (!f) checkOutput("accept_timeout", 135'(0), 135'(1));
    bus1.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit f;
    bus1.req_valid = 1'b0; bus1.req_op = '0; bus1.req_floating = 1'b0; bus1.req_form = 1'b0;
    bus1.req_precision = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_c = '0; bus1.req_d = '0;
    bus1.req_tag = '0; bus1.rsp_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_op = '0; bus4.req_floating = 1'b0; bus4.req_form = 1'b0;
    bus4.req_precision = '0; bus4.req_a = '0; bus4.req_b = '0; bus4.req_c = '0; bus4.req_d = '0;
    bus4.req_tag = '0; bus4.rsp_ready = 1'b1;
    rst_n = 1'b0;
    resetModel();
    #2;
    checkReset();
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b1;

    $display("[TB] basic add and subtract");
    sendOp(3'd0, 1'b0, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'd3, 1'b1);
    checkOutput("add_not_yet_valid", 135'(bus1.rsp_valid), 135'(0));
    idle(1'b1);
    checkOutput("add_result", 135'({bus1.rsp_valid, bus1.rsp_tag, bus1.rsp_result}), {67'd0, 1'b1, 4'd3, 64'd6});
    idle(1'b1);
    sendOp(3'd4, 1'b0, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'd5, 1'b1);
    idle(1'b1);
    checkOutput("sub_result", 135'(bus1.rsp_result), 135'(64'hFFFF_FFFF_FFFF_FFFC));
    checkOutput("sub_ops_done", 135'(ops1), 135'(2));
    idle(1'b1);

    $display("[TB] backpressure with full FIFO");
    poppedTags.delete();
    sendOp(3'd0, 1'b0, 1'b0, 2'd0, 32'd11, 32'd0, 32'd0, 32'd0, 4'd1, 1'b0);
    sendOp(3'd0, 1'b0, 1'b0, 2'd0, 32'd12, 32'd0, 32'd0, 32'd0, 4'd2, 1'b0);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 32'd13, 32'd0, 32'd0, 32'd0, 4'd3, 1'b0, f);
    checkOutput("full_req_ready", 135'(bus1.req_ready), 135'(0));
    checkOutput("full_head_tag", 135'(bus1.rsp_tag), 135'(1));
    sendOp(3'd0, 1'b0, 1'b0, 2'd0, 32'd13, 32'd0, 32'd0, 32'd0, 4'd3, 1'b1);
    for (int k = 0; k < 6; k++) idle(1'b1);
    checkOutput("order_count", 135'(poppedTags.size()), 135'(3));
    if (poppedTags.size() >= 3)
      checkOutput("order_tags", 135'({poppedTags[0], poppedTags[1], poppedTags[2]}), 135'(12'h123));

    $display("[TB] simultaneous push and pop");
    sendOp(3'd1, 1'b1, 1'b0, 2'd1, 32'hA5A5_0000, 32'd7, 32'd9, 32'h1234, 4'd6, 1'b0);
    idle(1'b0);
    sendOp(3'd2, 1'b0, 1'b1, 2'd3, 32'h0F0F_0F0F, 32'd1, 32'd2, 32'h8888_0000, 4'd7, 1'b0);
    idle(1'b1);
    checkOutput("pushpop_valid", 135'(bus1.rsp_valid), 135'(1));
    checkOutput("pushpop_tag", 135'(bus1.rsp_tag), 135'(7));
    idle(1'b1);
    idle(1'b1);

    $display("[TB] SETTLE_CYCLES=4 latency and mid-flight reset");
    bus4.req_valid = 1'b1; bus4.req_op = 3'd0; bus4.req_a = 32'd10; bus4.req_b = 32'd20;
    bus4.req_c = 32'd30; bus4.req_d = 32'd0; bus4.req_tag = 4'd9; bus4.rsp_ready = 1'b1;
    idle(1'b1);
    bus4.req_valid = 1'b0;
    checkOutput("d4_busy", 135'(busy4), 135'(1));
    for (int k = 1; k <= 4; k++) begin
      idle(1'b1);
      checkOutput("d4_rsp_valid", 135'(bus4.rsp_valid), 135'(k == 4));
    end
    checkOutput("d4_result", 135'({bus4.rsp_tag, bus4.rsp_result, ops4}), {51'd0, 4'd9, 64'd60, 16'd1});
    bus4.req_valid = 1'b1; bus4.req_tag = 4'd10;
    idle(1'b1);
    bus4.req_valid = 1'b0;
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b0;
    resetModel();
    #1;
    checkReset();
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b1;
    checkOutput("d4_ready_after_rst", 135'(bus4.req_ready), 135'(1));
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      checkOutput("d4_no_result", 135'({bus4.rsp_valid, ops4}), 135'(0));
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    2'($urandom), $urandom, $urandom, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 9) < 6, f);
    end
    for (int k = 0; k < 6; k++) idle(1'b1);

    $display("[TB] ops_done wrap");
    force dut1.ops_done = 16'hFFFF;
    #1;
    release dut1.ops_done;
    mOps = 16'hFFFF;
    sendOp(3'd0, 1'b0, 1'b0, 2'd0, 32'd5, 32'd6, 32'd7, 32'd0, 4'hE, 1'b1);
    idle(1'b1);
    checkOutput("wrap_ops_done", 135'(ops1), 135'(0));
    checkOutput("wrap_result", 135'({bus1.rsp_tag, bus1.rsp_result}), {67'd0, 4'hE, 64'd18});
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
